if_id_skid_reg: RTL

- Parametrised successor to the plain IF/ID pipeline register.
- Carries {instruction, instruction address} from fetch to decode with a valid/ready handshake, synchronous flush to NOP, and an optional 2-entry skid buffer.
- The skid buffer gives full throughput with a registered upstream ready, so the decode stall path is cut.
- Sits between the fetch unit and the decoder; one instance per fetch lane.

---
 rtl/if_id_skid_reg_pkg.sv | 9 +
 rtl/if_id_skid_reg_dffl.sv | 23 ++
 rtl/if_id_skid_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// Shared fetch/decode constants: instruction/address widths, NOP encoding and boot address.
package if_id_skid_reg_pkg;

  localparam int          INST_WIDTH      = 32;
  localparam int          INST_ADDR_WIDTH = 32;
  localparam logic [31:0] NOP             = 32'h0000_0013;
  localparam logic [31:0] INI_INST_ADDR   = 32'h8000_0000;

endpackage

// File: rtl/if_id_skid_reg_dffl.sv
// Load-enabled flop with synchronous clear-to-default; active-low reset also
// returns the flop to its default value.
module gnrl_dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [DW-1:0] dflt,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q <= dflt;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush to NOP and an
// optional 2-entry skid buffer that makes in_ready a pure flop output.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int                INST_W   = INST_WIDTH,
  parameter int                ADDR_W   = INST_ADDR_WIDTH,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP),
  parameter logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(INI_INST_ADDR),
  parameter bit                SKID_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_addr
);

  logic              m_valid;
  logic [INST_W-1:0] m_inst;
  logic [ADDR_W-1:0] m_addr;
  logic              m_ld;
  logic              m_valid_d;
  logic [INST_W-1:0] m_inst_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;

  if (SKID_EN) begin : g_skid
    // State lives in {s_valid, m_valid}: 00 empty, 01 one entry, 11 two entries.
    logic              s_valid;
    logic [INST_W-1:0] s_inst;
    logic [ADDR_W-1:0] s_addr;
    logic              s_ld;
    logic              s_valid_d;
    logic [INST_W-1:0] s_inst_d;
    logic [ADDR_W-1:0] s_addr_d;

    assign in_ready = ~s_valid;

    always_comb begin
      m_ld      = (~m_valid & in_fire) | out_fire;
      m_valid_d = s_valid | in_fire;
      m_inst_d  = NOP_INST;
      m_addr_d  = RST_ADDR;
      if (s_valid) begin
        m_inst_d = s_inst;
        m_addr_d = s_addr;
      end else if (in_fire) begin
        m_inst_d = in_inst;
        m_addr_d = in_addr;
      end
      // Skid fills only when main is stuck; it drains into main on out_fire.
      s_ld      = (m_valid & ~s_valid & in_fire & ~out_ready) | (s_valid & out_fire);
      s_valid_d = ~s_valid;
      s_inst_d  = s_valid ? NOP_INST : in_inst;
      s_addr_d  = s_valid ? RST_ADDR : in_addr;
    end

    gnrl_dffl #(.DW(1)) u_s_valid (
      .clk(clk), .rst(rst), .clr(flush), .ld(s_ld),
      .dflt(1'b0), .d(s_valid_d), .q(s_valid)
    );
    gnrl_dffl #(.DW(INST_W)) u_s_inst (
      .clk(clk), .rst(rst), .clr(flush), .ld(s_ld),
      .dflt(NOP_INST), .d(s_inst_d), .q(s_inst)
    );
    gnrl_dffl #(.DW(ADDR_W)) u_s_addr (
      .clk(clk), .rst(rst), .clr(flush), .ld(s_ld),
      .dflt(RST_ADDR), .d(s_addr_d), .q(s_addr)
    );
  end else begin : g_single
    assign in_ready = out_ready | ~m_valid;

    always_comb begin
      m_ld      = in_fire | out_fire;
      m_valid_d = in_fire;
      m_inst_d  = in_fire ? in_inst : NOP_INST;
      m_addr_d  = in_fire ? in_addr : RST_ADDR;
    end
  end

  gnrl_dffl #(.DW(1)) u_m_valid (
    .clk(clk), .rst(rst), .clr(flush), .ld(m_ld),
    .dflt(1'b0), .d(m_valid_d), .q(m_valid)
  );
  gnrl_dffl #(.DW(INST_W)) u_m_inst (
    .clk(clk), .rst(rst), .clr(flush), .ld(m_ld),
    .dflt(NOP_INST), .d(m_inst_d), .q(m_inst)
  );
  gnrl_dffl #(.DW(ADDR_W)) u_m_addr (
    .clk(clk), .rst(rst), .clr(flush), .ld(m_ld),
    .dflt(RST_ADDR), .d(m_addr_d), .q(m_addr)
  );

  assign out_valid = m_valid;
  assign out_inst  = m_inst;
  assign out_addr  = m_addr;

endmodule
